// File: rtl/caches_types_pkg.sv
// ---------------------------------------------------------------------------
// caches_types_pkg
// Purpose : types shared by the L1 caches and the coherence bus controller:
//           RAM handshake state, bus FSM states and the machine word type.
// Ports   : none (package).
// ---------------------------------------------------------------------------
package caches_types_pkg;
    typedef cpu_types_pkg::word_t word_t;

    // Handshake reported by the single-ported RAM each cycle.
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // One coherence transaction at a time; every path returns to IDLE.
    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        WB0    = 4'd1,
        WB1    = 4'd2,
        SNOOP  = 4'd3,
        FWD0   = 4'd4,
        FWD1   = 4'd5,
        LOAD0  = 4'd6,
        LOAD1  = 4'd7,
        INV    = 4'd8,
        ACK    = 4'd9,
        IFETCH = 4'd10
    } bus_state_t;
endpackage

// File: rtl/cpu_types_pkg.sv
// ---------------------------------------------------------------------------
// cpu_types_pkg
// Purpose : basic CPU-wide data types shared by the cache and bus blocks.
// Ports   : none (package).
// ---------------------------------------------------------------------------
package cpu_types_pkg;
    localparam int WORD_W = 32;
    typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
// Purpose : picks which core owns the next bus transaction. Data requests
//           always beat instruction requests. On a data tie core 0 wins,
//           unless BUS_RR_ARB_EN is defined, in which case the tie goes to
//           the core that did not receive the previous data grant.
// Ports   : CLK, nRST, take_i - only present with BUS_RR_ARB_EN; take_i
//                               high means the grant is consumed this cycle
//           dreq_i    - per-core data request (dREN | dWEN | cctrans)
//           ireq_i    - per-core instruction request
//           gnt       - winning core index
//           gnt_valid - some request is pending
//           is_instr  - the grant is for an instruction fetch
// Macro   : BUS_RR_ARB_EN
// ---------------------------------------------------------------------------
module bus_arbiter #(
    parameter int CPUS = 2
) (
`ifdef BUS_RR_ARB_EN
    input  logic            CLK,
    input  logic            nRST,
    input  logic            take_i,
`endif
    input  logic [CPUS-1:0] dreq_i,
    input  logic [CPUS-1:0] ireq_i,
    output logic            gnt,
    output logic            gnt_valid,
    output logic            is_instr
);
    logic tie_pick;

`ifdef BUS_RR_ARB_EN
    logic last_grant_q;

    // Remembers the owner of the most recent data transaction.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            last_grant_q <= 1'b1;
        end else if (take_i && (|dreq_i)) begin
            last_grant_q <= gnt;
        end
    end

    assign tie_pick = ~last_grant_q;
`else
    assign tie_pick = 1'b0;
`endif

    always_comb begin
        is_instr  = ~(|dreq_i);
        gnt_valid = (|dreq_i) | (|ireq_i);
        if (|dreq_i) begin
            gnt = (&dreq_i) ? tie_pick : ~dreq_i[0];
        end else begin
            gnt = ~ireq_i[0];
        end
    end
endmodule

// File: rtl/coherence_bus_ctrl.sv
// ---------------------------------------------------------------------------
// coherence_bus_ctrl
// Purpose : snooping MSI bus controller for two cores (icache + dcache each)
//           sharing one single-ported RAM. Serialises write-backs, read
//           misses (with dirty-line forwarding from the other dcache),
//           invalidations, clean-frame acknowledgements and instruction
//           fetches.
// Ports   : CLK, nRST (async, active-low)
//           iREN/iaddr -> iwait/iload            icache side
//           dREN/dWEN/daddr/dstore/cctrans/ccwrite -> dwait/dload  dcache
//           ccwait/ccinv/ccsnoopaddr             snoop into the other dcache
//           ramREN/ramWEN/ramaddr/ramstore, ramload/ramstate   RAM side
// Macro   : BUS_RR_ARB_EN selects round-robin arbitration on data ties.
// ---------------------------------------------------------------------------
module coherence_bus_ctrl
    import caches_types_pkg::*;
#(
    parameter int CPUS   = 2,
    parameter int ADDR_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [CPUS-1:0]   iREN,
    input  logic [ADDR_W-1:0] iaddr       [CPUS-1:0],
    output logic [CPUS-1:0]   iwait,
    output logic [ADDR_W-1:0] iload       [CPUS-1:0],
    input  logic [CPUS-1:0]   dREN,
    input  logic [CPUS-1:0]   dWEN,
    input  logic [ADDR_W-1:0] daddr       [CPUS-1:0],
    input  logic [ADDR_W-1:0] dstore      [CPUS-1:0],
    input  logic [CPUS-1:0]   cctrans,
    input  logic [CPUS-1:0]   ccwrite,
    output logic [CPUS-1:0]   dwait,
    output logic [ADDR_W-1:0] dload       [CPUS-1:0],
    output logic [CPUS-1:0]   ccwait,
    output logic [CPUS-1:0]   ccinv,
    output logic [ADDR_W-1:0] ccsnoopaddr [CPUS-1:0],
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [ADDR_W-1:0] ramstore,
    input  logic [ADDR_W-1:0] ramload,
    input  ramstate_t         ramstate
);
    bus_state_t        state_q, state_d;
    logic              gnt_q, gnt_d;
    logic              snp;
    logic              access;
    logic [CPUS-1:0]   dreq;
    logic              arb_gnt, arb_valid, arb_instr;
    logic [ADDR_W-1:0] ccsnoopaddr_q [CPUS-1:0];

    assign dreq   = dREN | dWEN | cctrans;
    assign snp    = ~gnt_q;
    // ERROR deliberately falls into the "not ready" case so the state holds.
    assign access = (ramstate == ACCESS);

    bus_arbiter #(.CPUS(CPUS)) u_arb (
`ifdef BUS_RR_ARB_EN
        .CLK       (CLK),
        .nRST      (nRST),
        .take_i    (state_q == IDLE),
`endif
        .dreq_i    (dreq),
        .ireq_i    (iREN),
        .gnt       (arb_gnt),
        .gnt_valid (arb_valid),
        .is_instr  (arb_instr)
    );

    // Next-state: requests are only looked at in IDLE; once started, a
    // transaction runs to completion even if the request drops.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    gnt_d = arb_gnt;
                    if (arb_instr)             state_d = IFETCH;
                    else if (dWEN[arb_gnt])    state_d = WB0;
                    else if (dREN[arb_gnt])    state_d = SNOOP;
                    else if (ccwrite[arb_gnt]) state_d = INV;
                    else                       state_d = ACK;
                end
            end
            WB0:    if (access) state_d = WB1;
            WB1:    if (access) state_d = IDLE;
            SNOOP:  state_d = cctrans[snp] ? FWD0 : LOAD0;
            FWD0:   if (access) state_d = FWD1;
            FWD1:   if (access) state_d = IDLE;
            LOAD0:  if (access) state_d = LOAD1;
            LOAD1:  if (access) state_d = IDLE;
            INV:    state_d = IDLE;
            ACK:    state_d = IDLE;
            IFETCH: if (access) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
        end
    end

    // Snoop address is captured once when a snoop starts and then held, so
    // it stays stable while ccwait is low.
    for (genvar gi = 0; gi < CPUS; gi++) begin : g_snoop_addr
        always_ff @(posedge CLK or negedge nRST) begin
            if (!nRST) begin
                ccsnoopaddr_q[gi] <= '0;
            end else if (state_q == IDLE && gnt_d != 1'(gi)) begin
                if (state_d == SNOOP) begin
                    ccsnoopaddr_q[gi] <= daddr[gnt_d];
                end else if (state_d == INV) begin
                    ccsnoopaddr_q[gi] <= {daddr[gnt_d][ADDR_W-1:3], 3'b000};
                end
            end
        end
        assign ccsnoopaddr[gi] = ccsnoopaddr_q[gi];
    end

    // Outputs: IDLE drives exactly the reset values, so an asynchronous
    // reset (which forces IDLE) clears every output immediately.
    always_comb begin
        iwait    = '1;
        dwait    = '1;
        ccwait   = '0;
        ccinv    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        for (int c = 0; c < CPUS; c++) begin
            iload[c] = '0;
            dload[c] = '0;
        end
        case (state_q)
            WB0, WB1: begin
                ramWEN   = 1'b1;
                ramaddr  = daddr[gnt_q];
                ramstore = dstore[gnt_q];
                if (access) dwait[gnt_q] = 1'b0;
            end
            SNOOP: begin
                ccwait[snp] = 1'b1;
                ccinv[snp]  = ccwrite[gnt_q];
            end
            FWD0, FWD1: begin
                // Dirty line goes to the requester and to RAM in one beat;
                // the snooper's address names the word being forwarded.
                ccwait[snp]  = 1'b1;
                ramWEN       = 1'b1;
                ramaddr      = daddr[snp];
                ramstore     = dstore[snp];
                dload[gnt_q] = dstore[snp];
                if (access) begin
                    dwait[gnt_q] = 1'b0;
                    dwait[snp]   = 1'b0;
                end
            end
            LOAD0, LOAD1: begin
                ccwait[snp] = 1'b1;
                ccinv[snp]  = ccwrite[gnt_q];
                ramREN      = 1'b1;
                ramaddr     = daddr[gnt_q];
                if (access) begin
                    dload[gnt_q] = ramload;
                    dwait[gnt_q] = 1'b0;
                end
            end
            INV: begin
                ccwait[snp]  = 1'b1;
                ccinv[snp]   = 1'b1;
                dwait[gnt_q] = 1'b0;
            end
            ACK: begin
                dwait[gnt_q] = 1'b0;
            end
            IFETCH: begin
                ramREN  = 1'b1;
                ramaddr = iaddr[gnt_q];
                if (access) begin
                    iload[gnt_q] = ramload;
                    iwait[gnt_q] = 1'b0;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// ---------------------------------------------------------------------------
// tb_coherence_bus_ctrl
// Directed bench for coherence_bus_ctrl. Inputs change 1 time unit after the
// rising edge; outputs are checked on the falling edge. Tie-break
// expectations follow BUS_RR_ARB_EN.
// ---------------------------------------------------------------------------
module tb_coherence_bus_ctrl;
    import caches_types_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [1:0]  iREN, dREN, dWEN, cctrans, ccwrite;
    logic [31:0] iaddr [1:0];
    logic [31:0] daddr [1:0];
    logic [31:0] dstore [1:0];
    logic [1:0]  iwait, dwait, ccwait, ccinv;
    logic [31:0] iload [1:0];
    logic [31:0] dload [1:0];
    logic [31:0] ccsnoopaddr [1:0];
    logic        ramREN, ramWEN;
    logic [31:0] ramaddr, ramstore, ramload;
    ramstate_t   ramstate;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    logic        w, l;
    logic [31:0] base_w, base_l;
    logic [1:0]  dw_w, dw_l;

    coherence_bus_ctrl #(.CPUS(2), .ADDR_W(32)) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .iREN        (iREN),
        .iaddr       (iaddr),
        .iwait       (iwait),
        .iload       (iload),
        .dREN        (dREN),
        .dWEN        (dWEN),
        .daddr       (daddr),
        .dstore      (dstore),
        .cctrans     (cctrans),
        .ccwrite     (ccwrite),
        .dwait       (dwait),
        .dload       (dload),
        .ccwait      (ccwait),
        .ccinv       (ccinv),
        .ccsnoopaddr (ccsnoopaddr),
        .ramREN      (ramREN),
        .ramWEN      (ramWEN),
        .ramaddr     (ramaddr),
        .ramstore    (ramstore),
        .ramload     (ramload),
        .ramstate    (ramstate)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic mid();
        @(negedge CLK);
    endtask

    task automatic clear_req();
        iREN = '0; dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
    endtask

    initial begin
        nRST = 1'b0;
        clear_req();
        iaddr[0] = '0; iaddr[1] = '0;
        daddr[0] = '0; daddr[1] = '0;
        dstore[0] = '0; dstore[1] = '0;
        ramload = '0;
        ramstate = FREE;

        // ---- reset values
        mid(); mid();
        chk("rst dwait", dwait, 2'b11);
        chk("rst iwait", iwait, 2'b11);
        chk("rst ccwait", ccwait, 2'b00);
        chk("rst ccinv", ccinv, 2'b00);
        chk("rst ramREN", ramREN, 1'b0);
        chk("rst ramWEN", ramWEN, 1'b0);
        chk("rst ramaddr", ramaddr, 32'h0);
        chk("rst dload0", dload[0], 32'h0);
        chk("rst snpaddr1", ccsnoopaddr[1], 32'h0);

        // ---- 1: core 0 read miss, snooper clean
        cyc(); nRST = 1'b1; dREN[0] = 1'b1; daddr[0] = 32'h100;
        ramstate = ACCESS; ramload = 32'hAAAA;
        mid(); chk("t1 idle dwait", dwait, 2'b11);
        $display("t1 read miss core0 addr 100");
        cyc(); mid();
        chk("t1 snoop ccwait", ccwait, 2'b10);
        chk("t1 snoop ccinv", ccinv, 2'b00);
        chk("t1 snoop addr", ccsnoopaddr[1], 32'h100);
        chk("t1 snoop ramREN", ramREN, 1'b0);
        chk("t1 snoop dwait", dwait, 2'b11);
        cyc(); mid();
        chk("t1 load0 ramREN", ramREN, 1'b1);
        chk("t1 load0 ramaddr", ramaddr, 32'h100);
        chk("t1 load0 dload", dload[0], 32'hAAAA);
        chk("t1 load0 dwait", dwait, 2'b10);
        chk("t1 load0 ccwait", ccwait, 2'b10);
        cyc(); daddr[0] = 32'h104; ramload = 32'hBBBB; mid();
        chk("t1 load1 ramaddr", ramaddr, 32'h104);
        chk("t1 load1 dload", dload[0], 32'hBBBB);
        chk("t1 load1 dwait", dwait, 2'b10);
        cyc(); clear_req(); mid();
        chk("t1 end dwait", dwait, 2'b11);
        chk("t1 end ccwait", ccwait, 2'b00);
        chk("t1 end ramREN", ramREN, 1'b0);
        chk("t1 end snpaddr hold", ccsnoopaddr[1], 32'h100);

        // ---- 2: core 1 read-exclusive, core 0 forwards dirty line
        cyc(); dREN[1] = 1'b1; ccwrite[1] = 1'b1; daddr[1] = 32'h200; mid();
        chk("t2 idle dwait", dwait, 2'b11);
        $display("t2 read-x core1 addr 200 with forward");
        cyc(); cctrans[0] = 1'b1; daddr[0] = 32'h200; dstore[0] = 32'h1111; mid();
        chk("t2 snoop ccwait", ccwait, 2'b01);
        chk("t2 snoop ccinv", ccinv, 2'b01);
        chk("t2 snoop addr", ccsnoopaddr[0], 32'h200);
        cyc(); mid();
        chk("t2 fwd0 ramWEN", ramWEN, 1'b1);
        chk("t2 fwd0 ramREN", ramREN, 1'b0);
        chk("t2 fwd0 ramaddr", ramaddr, 32'h200);
        chk("t2 fwd0 ramstore", ramstore, 32'h1111);
        chk("t2 fwd0 dload1", dload[1], 32'h1111);
        chk("t2 fwd0 dwait", dwait, 2'b00);
        cyc(); daddr[0] = 32'h204; dstore[0] = 32'h2222; daddr[1] = 32'h204; mid();
        chk("t2 fwd1 ramaddr", ramaddr, 32'h204);
        chk("t2 fwd1 ramstore", ramstore, 32'h2222);
        chk("t2 fwd1 dload1", dload[1], 32'h2222);
        chk("t2 fwd1 dwait", dwait, 2'b00);
        chk("t2 fwd1 ramREN", ramREN, 1'b0);
        cyc(); clear_req(); mid();
        chk("t2 end ramWEN", ramWEN, 1'b0);
        chk("t2 end dwait", dwait, 2'b11);
        chk("t2 end ccwait", ccwait, 2'b00);

        // ---- 3: core 0 invalidation
        cyc(); cctrans[0] = 1'b1; ccwrite[0] = 1'b1; daddr[0] = 32'h30C; mid();
        $display("t3 invalidate core0 addr 30c");
        cyc(); clear_req(); mid();
        chk("t3 inv ccwait", ccwait, 2'b10);
        chk("t3 inv ccinv", ccinv, 2'b10);
        chk("t3 inv addr", ccsnoopaddr[1], 32'h308);
        chk("t3 inv dwait", dwait, 2'b10);
        chk("t3 inv ramREN", ramREN, 1'b0);
        chk("t3 inv ramWEN", ramWEN, 1'b0);
        cyc(); mid();
        chk("t3 end ccwait", ccwait, 2'b00);
        chk("t3 end ccinv", ccinv, 2'b00);
        chk("t3 end dwait", dwait, 2'b11);
        chk("t3 end snpaddr hold", ccsnoopaddr[1], 32'h308);

        // ---- 5: instruction fetch waits behind a write-back with RAM busy
        cyc(); iREN[0] = 1'b1; iaddr[0] = 32'h40; dWEN[1] = 1'b1;
        daddr[1] = 32'h600; dstore[1] = 32'hC0; ramstate = BUSY; mid();
        $display("t5 wb core1 addr 600 vs ifetch core0 addr 40");
        cyc(); mid();
        chk("t5 busy1 ramWEN", ramWEN, 1'b1);
        chk("t5 busy1 ramaddr", ramaddr, 32'h600);
        chk("t5 busy1 ramstore", ramstore, 32'hC0);
        chk("t5 busy1 dwait", dwait, 2'b11);
        chk("t5 busy1 iwait", iwait, 2'b11);
        cyc(); mid();
        chk("t5 busy2 dwait", dwait, 2'b11);
        cyc(); ramstate = ERROR; mid();
        chk("t5 error dwait", dwait, 2'b11);
        chk("t5 error ramaddr", ramaddr, 32'h600);
        cyc(); ramstate = ACCESS; mid();
        chk("t5 wb0 dwait", dwait, 2'b01);
        chk("t5 wb0 iwait", iwait, 2'b11);
        cyc(); daddr[1] = 32'h604; mid();
        chk("t5 wb1 ramaddr", ramaddr, 32'h604);
        chk("t5 wb1 dwait", dwait, 2'b01);
        cyc(); dWEN[1] = 1'b0; ramload = 32'h1234; mid();
        chk("t5 idle iwait", iwait, 2'b11);
        chk("t5 idle ramREN", ramREN, 1'b0);
        cyc(); mid();
        chk("t5 ifetch ramREN", ramREN, 1'b1);
        chk("t5 ifetch ramaddr", ramaddr, 32'h40);
        chk("t5 ifetch iload", iload[0], 32'h1234);
        chk("t5 ifetch iwait", iwait, 2'b10);
        cyc(); clear_req(); mid();
        chk("t5 end iwait", iwait, 2'b11);
        chk("t5 end iload", iload[0], 32'h0);

        // ---- 6: reset in the middle of LOAD0
        cyc(); dREN[0] = 1'b1; daddr[0] = 32'h700; mid();
        $display("t6 reset during load0 addr 700");
        cyc(); ramstate = BUSY; mid();
        chk("t6 snoop ccwait", ccwait, 2'b10);
        cyc(); mid();
        chk("t6 load0 ramREN", ramREN, 1'b1);
        chk("t6 load0 ramaddr", ramaddr, 32'h700);
        #1 nRST = 1'b0;
        #1;
        chk("t6 rst ramREN", ramREN, 1'b0);
        chk("t6 rst dwait", dwait, 2'b11);
        chk("t6 rst iwait", iwait, 2'b11);
        chk("t6 rst ccwait", ccwait, 2'b00);
        chk("t6 rst ramaddr", ramaddr, 32'h0);
        chk("t6 rst snpaddr", ccsnoopaddr[1], 32'h0);
        cyc(); nRST = 1'b1; clear_req(); ramstate = ACCESS; mid();
        chk("t6 idle ramREN", ramREN, 1'b0);
        chk("t6 idle dwait", dwait, 2'b11);
        // clean-frame acknowledge from core 1 after reset
        cyc(); cctrans[1] = 1'b1; mid();
        chk("t6 ack-req ramREN", ramREN, 1'b0);
        cyc(); clear_req(); mid();
        $display("t6 ack core1");
        chk("t6 ack dwait", dwait, 2'b01);
        chk("t6 ack ccwait", ccwait, 2'b00);
        chk("t6 ack ramREN", ramREN, 1'b0);
        chk("t6 ack ramWEN", ramWEN, 1'b0);

        // ---- 4: simultaneous write-backs, twice
        cyc(); dWEN = 2'b11; daddr[0] = 32'h400; dstore[0] = 32'hA0;
        daddr[1] = 32'h500; dstore[1] = 32'hB0; mid();
        chk("t4 r1 idle dwait", dwait, 2'b11);
        $display("t4 round1 tie");
        cyc(); mid();
        chk("t4 r1 wb0 ramaddr", ramaddr, 32'h400);
        chk("t4 r1 wb0 ramstore", ramstore, 32'hA0);
        chk("t4 r1 wb0 dwait", dwait, 2'b10);
        cyc(); daddr[0] = 32'h404; mid();
        chk("t4 r1 wb1 ramaddr", ramaddr, 32'h404);
        chk("t4 r1 wb1 dwait", dwait, 2'b10);
        cyc(); dWEN = 2'b00; mid();
        chk("t4 r1 end dwait", dwait, 2'b11);

`ifdef BUS_RR_ARB_EN
        w = 1'b1;
`else
        w = 1'b0;
`endif
        l      = ~w;
        base_w = w ? 32'h500 : 32'h400;
        base_l = l ? 32'h500 : 32'h400;
        dw_w   = w ? 2'b01 : 2'b10;
        dw_l   = l ? 2'b01 : 2'b10;

        cyc(); dWEN = 2'b11; daddr[0] = 32'h400; daddr[1] = 32'h500; mid();
        $display("t4 round2 tie expected winner %0d", w);
        cyc(); mid();
        chk("t4 r2 wb0 ramaddr", ramaddr, base_w);
        chk("t4 r2 wb0 dwait", dwait, dw_w);
        cyc(); daddr[w] = base_w + 32'h4; mid();
        chk("t4 r2 wb1 ramaddr", ramaddr, base_w + 32'h4);
        chk("t4 r2 wb1 dwait", dwait, dw_w);
        cyc(); dWEN[w] = 1'b0; mid();
        chk("t4 r2 idle dwait", dwait, 2'b11);
        cyc(); mid();
        chk("t4 loser wb0 ramaddr", ramaddr, base_l);
        chk("t4 loser wb0 ramstore", ramstore, l ? 32'hB0 : 32'hA0);
        chk("t4 loser wb0 dwait", dwait, dw_l);
        cyc(); daddr[l] = base_l + 32'h4; mid();
        chk("t4 loser wb1 ramaddr", ramaddr, base_l + 32'h4);
        chk("t4 loser wb1 dwait", dwait, dw_l);
        cyc(); clear_req(); mid();
        chk("t4 end ramWEN", ramWEN, 1'b0);
        chk("t4 end dwait", dwait, 2'b11);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/coherence_bus_ctrl.md
# coherence_bus_ctrl

Snooping MSI bus controller between two cores' L1 caches (one icache + one dcache each) and the single-ported RAM. It arbitrates data and instruction requests and serializes every coherence transaction. It drives snoops (`ccwait`/`ccinv`/`ccsnoopaddr`) into the non-requesting dcache, and routes dirty-line forwarding from that dcache to both the requester and RAM. It sits directly downstream of both dcaches.

## Interface
Parameters:
- `CPUS`, 2: number of cores; only 2 is supported.
- `ADDR_W`, 32: word-address width (`word_t`).

Ports (per-cache arrays are `[CPUS-1:0]`):
- `CLK` in 1: clock.
- `nRST` in 1: reset, asynchronous, active-low.
- `iREN` in [CPUS]: icache read request.
- `iaddr` in [CPUS]x32: icache address.
- `iwait` out [CPUS]: icache stall; 0 for one cycle = `iload` valid.
- `iload` out [CPUS]x32: icache data.
- `dREN`, `dWEN` in [CPUS]: dcache read / write-back request.
- `daddr`, `dstore` in [CPUS]x32: dcache address / store data.
- `cctrans` in [CPUS]: dcache coherence transition / transaction start / forward-ready.
- `ccwrite` in [CPUS]: requester intends M.
- `dwait` out [CPUS]: dcache stall; 0 for one cycle = word accepted / `dload` valid.
- `dload` out [CPUS]x32: dcache data.
- `ccwait` out [CPUS]: snoop is active on this cache.
- `ccinv` out [CPUS]: invalidate the snooped line.
- `ccsnoopaddr` out [CPUS]x32: snoop address.
- `ramREN`, `ramWEN` out 1: RAM read / write.
- `ramaddr`, `ramstore` out 32: RAM address / write data.
- `ramload` in 32: RAM read data.
- `ramstate` in `ramstate_t`: FREE, BUSY, ACCESS or ERROR.

## Operation
- Reset values:
  - `dwait` = `iwait` = all 1s.
  - `ccwait` = `ccinv` = 0.
  - `ramREN` = `ramWEN` = 0.
  - All address and data outputs 0.
  - State = IDLE; `last_grant` = 1.
- Data request from cache *i*: `dREN[i] | dWEN[i] | cctrans[i]`. Data requests beat instruction requests.
- Arbitration between cores uses fixed priority to core 0 (see Configuration). The grant is latched in `gnt` for the whole transaction. The other core is `snp = ~gnt`.
- States:
  - IDLE: on a data request, latch `gnt` and classify:
    - `dWEN` → WB0.
    - `dREN` → SNOOP.
    - `cctrans & ccwrite` (no `dREN`/`dWEN`) → INV.
    - `cctrans` alone → ACK.
  - IDLE otherwise: any `iREN` → IFETCH (core 0 first).
  - WB0/WB1: `ramWEN`=1, `ramaddr`=`daddr[gnt]`, `ramstore`=`dstore[gnt]`. On `ramstate==ACCESS`, `dwait[gnt]`=0 and advance; WB1 → IDLE. The word-1 address comes from the cache.
  - SNOOP (1 cycle):
    - `ccwait[snp]`=1, `ccinv[snp]`=`ccwrite[gnt]`, `ccsnoopaddr[snp]`=`daddr[gnt]`.
    - Next: `cctrans[snp]` → FWD0, else LOAD0.
  - FWD0/FWD1 (dirty line in snooper):
    - `ccwait[snp]` held; `ramWEN`=1; `ramaddr`=`daddr[snp]`; `ramstore`=`dload[gnt]`=`dstore[snp]`.
    - On ACCESS: `dwait[gnt]`=0 and `dwait[snp]`=0 in the same cycle, then advance. FWD1 → IDLE.
    - The requester's dREN is satisfied without a RAM read.
  - LOAD0/LOAD1:
    - `ccwait[snp]` held, `ccinv[snp]`=`ccwrite[gnt]`; `ramREN`=1, `ramaddr`=`daddr[gnt]`.
    - On ACCESS: `dload[gnt]`=`ramload`, `dwait[gnt]`=0. LOAD1 → IDLE.
  - INV (1 cycle): `ccwait[snp]`=`ccinv[snp]`=1, `ccsnoopaddr[snp]`={`daddr[gnt]`[31:3],3'b0}, `dwait[gnt]`=0 → IDLE.
  - ACK (1 cycle): `dwait[gnt]`=0, no bus or snoop action → IDLE. This covers a dump pass over clean frames.
  - IFETCH: `ramREN`, `ramaddr`=`iaddr[g]`. On ACCESS: `iload[g]`=`ramload`, `iwait[g]`=0 → IDLE.
- `ramstate==ERROR` is treated as BUSY; the state holds.
- `ccsnoopaddr` holds its last value when `ccwait` is 0.

## Timing
- Requests are sampled in IDLE. The first RAM strobe appears the next cycle.
- Minimum transaction lengths (with `ramstate`=ACCESS on the first strobe):
  - Read miss: 4 cycles (IDLE, SNOOP, LOAD0, LOAD1).
  - Write-back: 3 cycles.
  - Invalidation: 2 cycles.
- Each `dwait`/`iwait` low pulse is exactly 1 cycle per word.
- A request that drops while its transaction is in flight does not abort it: the FSM completes the sequence.
- Simultaneous requests from both dcaches: the loser sees `dwait`=1 throughout and is served the cycle after the winner returns to IDLE.
- Reset mid-transaction returns all outputs to reset values immediately.

## Configuration
- `BUS_RR_ARB_EN` defined: round-robin arbitration. On a tie, grant goes to `~last_grant`. `last_grant` updates on every data grant.
- Not defined: fixed priority to core 0. `last_grant` is not implemented.

## Structure
- Shared `caches_types_pkg` holds:
  - `bus_state_t` (IDLE, ARB-free set above).
  - `ramstate_t`.
  - `word_t` from `cpu_types_pkg`.
- Sub-module `bus_arbiter`: request vectors in; `gnt`, `gnt_valid`, `is_instr` out; holds `last_grant` when RR is enabled.

## Test plan
1. Core 0 `dREN`, `daddr`=0x100, snooper clean (`cctrans[1]`=0), RAM returns 0xAAAA/0xBBBB → `ccwait[1]` high, `ccinv[1]`=0, `dload[0]` = 0xAAAA then 0xBBBB, two single-cycle `dwait[0]` lows.
2. Core 1 `dREN` + `ccwrite`, `daddr`=0x200, core 0 answers `cctrans`, `dstore`=0x1111/0x2222 → `dload[1]` = `ramstore` = each word, `ccinv[0]`=1, `ramWEN` at 0x200/0x204, `ramREN` never asserted.
3. Core 0 `cctrans`+`ccwrite`, `daddr`=0x30C → single-cycle `ccinv[1]`=`ccwait[1]`=1, `ccsnoopaddr[1]`=0x308, `dwait[0]` low the next cycle.
4. Both dcaches request in the same cycle, repeated twice, with and without `BUS_RR_ARB_EN` → grants 0,1 vs 0,0; the loser's `dwait` stays at 1 meanwhile.
5. `iREN[0]` together with `dWEN[1]` → write-back completes first, then `iload[0]`; with `ramstate` BUSY for 3 cycles, all waits stay high.
6. `nRST` low during LOAD0 → `ramREN`=0, all waits 1, state IDLE next cycle.
